// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter and launch sequencer sharing one uart_tx among N_REQ byte requesters
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    output logic [N_REQ-1:0]           gnt,
    output logic                       ready,
    output logic [DATA_W-1:0]          tx_data,
    input  logic                       tdre,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(N_REQ)-1:0]   done_id,
    output logic                       err
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_HI, WAIT_LO} state_t;
    state_t state, state_nxt;
    logic [IW-1:0] owner, last, winner;
    logic [CW-1:0] cnt;
    logic [DATA_W-1:0] slot [N_REQ];
    logic timed_out, fin_ok, fin_to;
    int k;
    for (genvar g = 0; g < N_REQ; g++) begin : g_slot
        assign slot[g] = req_data[g*DATA_W +: DATA_W];
    end
    assign timed_out = cnt == CW'(TIMEOUT - 1);
    assign fin_ok = state == WAIT_LO && !tdre;
    assign fin_to = state == WAIT_HI && !tdre && timed_out;
    always_comb begin
        winner = last;
        k = 0;
        for (int i = N_REQ; i >= 1; i--) begin
            k = (int'(last) + i) % N_REQ;
            if (req[IW'(k)]) winner = IW'(k);
        end
    end
    always_ff @(posedge clk or negedge clr_n)
        if (!clr_n) begin
            state   <= IDLE;
            owner   <= '0;
            last    <= IW'(N_REQ - 1);
            tx_data <= '0;
            cnt     <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            done_id <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && |req) begin
                owner   <= winner;
                last    <= winner;
                tx_data <= slot[winner];
            end
            cnt  <= (state == WAIT_HI && state_nxt == WAIT_HI) ? cnt + 1'b1 : '0;
            done <= fin_ok;
            err  <= fin_to;
            if (fin_ok || fin_to) done_id <= owner;
        end
    always_comb
        state_nxt = state == IDLE    ? (|req ? LAUNCH : IDLE) :
                    state == LAUNCH  ? WAIT_HI :
                    state == WAIT_HI ? (tdre ? WAIT_LO : timed_out ? IDLE : WAIT_HI) :
                    (tdre ? WAIT_LO : IDLE);
    always_comb begin
        busy  = state != IDLE;
        ready = state == LAUNCH;
        gnt   = ready ? N_REQ'(1) << owner : '0;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and launch sequencer that shares one `uart_tx` transmitter among `N_REQ` byte requesters. It latches the winning requester's byte, drives the transmitter's `ready`/`tx_data` inputs with a single-cycle launch pulse, and tracks `tdre` to detect the end of the frame. It then reports completion and re-arbitrates. It sits between the requesters and the `TX` side of `uart_if`; it never drives the transmitter's `clr`.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `DATA_W`, 8: byte width; must match transmitter `tx_data`.
- `TIMEOUT`, 64: maximum cycles to wait for `tdre` to rise after launch (≥ 2).

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `clr_n`  in  1  reset, asynchronous, active-low.
- `req`  in  N_REQ  per-requester request; held high with stable data until the matching `gnt`.
- `req_data`  in  N_REQ*DATA_W  requester i's byte at bits [i*DATA_W +: DATA_W].
- `gnt`  out  N_REQ  one-hot, one-cycle pulse: requester's byte has been latched.
- `ready`  out  1  to transmitter `ready`; one-cycle launch pulse.
- `tx_data`  out  DATA_W  to transmitter `tx_data`; holds the latched byte.
- `tdre`  in  1  from transmitter; high during its stop state.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse: frame finished.
- `done_id`  out  clog2(N_REQ)  owner of the finished or timed-out frame; valid with `done`/`err`, otherwise holds last value.
- `err`  out  1  one-cycle pulse: `tdre` never rose within TIMEOUT cycles.

## Operation
- States: IDLE, LAUNCH, WAIT_HI, WAIT_LO.
- **IDLE:** if any `req` bit is set, pick the winner by round-robin.
  - The search starts at `last+1` and wraps at `N_REQ-1 → 0`.
  - On that edge: latch `req_data` slice into `tx_data`, `owner<=winner`, `last<=winner`, `gnt[winner]<=1`, `ready<=1`, go to LAUNCH.
  - If no request is present, stay in IDLE.
- **LAUNCH:** `ready`=1 and `gnt` pulse visible for this one cycle; the transmitter, idle, samples them at the next edge.
  - Next edge: `ready<=0`, `gnt<=0`, `cnt<=0`, go to WAIT_HI.
- **WAIT_HI:**
  - `tdre`=1: go to WAIT_LO.
  - Otherwise, if `cnt==TIMEOUT-1`: `err<=1`, `done_id<=owner`, go to IDLE.
  - Otherwise `cnt<=cnt+1`.
- **WAIT_LO:** when `tdre`=0 (transmitter back in idle), `done<=1`, `done_id<=owner`, go to IDLE.
- Arbitration happens only in IDLE. Requests arriving during a frame wait and are not lost while held.
- A `req` dropped before its grant is simply not served, with no side effects.
- `req` bits for non-winners are ignored that cycle.
- `tx_data` holds its value after the frame until the next grant.
- `cnt` width is clog2(TIMEOUT); no wrap is possible because it is cleared on exit.

## Timing
- **Reset (clr_n=0, any time, including mid-frame):**
  - State IDLE; `last`=N_REQ-1, so the first search starts at requester 0.
  - All outputs 0: `gnt`, `ready`, `tx_data`, `busy`, `done`, `done_id`, `err`, `cnt`.
  - A frame already in the transmitter is abandoned. The transmitter's own reset is the system's responsibility.
- **Grant latency:** a request seen in IDLE at edge k produces `gnt`, `ready` and `tx_data` valid in cycle k→k+1. The transmitter captures at edge k+1.
- **Frame-to-next-grant:** `done` is high in the cycle after `tdre` is seen low. The controller is then in IDLE, and the next grant is issued at that same edge if a request is pending. Minimum gap is `done` cycle → `ready` in the following cycle.
- **Busy window:** `busy` is high from LAUNCH through the edge leaving WAIT_HI or WAIT_LO. It is 0 in the cycle carrying `done` or `err`.
- **Timeout:** `err` is asserted exactly TIMEOUT cycles after entering WAIT_HI with `tdre` held 0. `done` is not asserted for that frame.
- **Exclusivity:** `done` and `err` are never high together; at most one `gnt` bit is high in any cycle.
- **Glitch on `tdre`:** `tdre` seen high for only one cycle still advances WAIT_HI → WAIT_LO. The return to 0 then completes the frame.

## Test plan
1. **Single requester.** Reset, then `req`=0001 with `req_data[7:0]`=0xA5, real `uart_tx` (bit_time=2) and `uart_rx` attached.
   - `gnt`=0001 for one cycle, `ready` one cycle, `tx_data`=0xA5.
   - Then `done` with `done_id`=0, and `rx_data`=0xA5.
2. **All requesters simultaneous.** `req`=1111 held, bytes 0x11, 0x22, 0x33, 0x44 until each grant.
   - Grants in order 0, 1, 2, 3.
   - Four `done` pulses with `done_id` 0, 1, 2, 3; receiver sees the bytes in the same order.
3. **Round-robin pointer.** After serving requester 2, assert `req`=1001.
   - Requester 3 is granted first, then 0.
   - `err` stays 0 throughout.
4. **Timeout.** `tdre` tied 0, `req`=0100.
   - `gnt`=0100.
   - `err` pulses exactly 64 cycles after WAIT_HI entry, with `done_id`=2.
   - `done` stays 0; `busy` is 0 the cycle of `err`.
5. **Reset mid-frame.** Pull `clr_n` low while in WAIT_LO.
   - All outputs are 0 immediately, without waiting for a clock edge.
   - After release with `req`=1000, requester 3 is granted, since the search starts from 0.
6. **Withdrawn request.** `req`=0010 pulsed for zero edges in IDLE, i.e. deasserted before a rising edge.
   - No `gnt` and no `ready`; `busy` stays 0.
